multicycle_controller: RTL

Control FSM for the multicycle RISC-V core. It sequences the shared datapath (single ALU, unified memory, instruction/data registers) through fetch, decode, execute, memory and writeback, one state per clock. It also generates the 3-bit ALUControl code that drives the ALU directly. Inputs come from the instruction register and the ALU zero flag; outputs drive the datapath muxes and write enables.

---
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RISC-V core: sequences fetch/decode/execute/
// memory/writeback and decodes the 3-bit ALUControl for the shared ALU.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  state_t     state_reg, state_next;
  logic       pc_update, branch, taken;
  logic       ir_write, reg_write, mem_write, done, illegal_op;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    illegal_op = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    case (state_reg)
      S_FETCH: begin
        ir_write   = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECUTER;
          7'b0010011:             state_next = S_EXECUTEI;
          7'b1101111:             state_next = S_JAL;
          7'b1100011:             state_next = S_BRANCH;
          7'b0110111:             state_next = S_LUI;
          default: begin
            state_next = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      default: taken = 1'b0;
    endcase
  end

  // Enables are masked while reset is held, since the state already reads FETCH.
  assign PCWrite    = ~reset & (pc_update | (branch & taken));
  assign IRWrite    = ~reset & ir_write;
  assign RegWrite   = ~reset & reg_write;
  assign MemWrite   = ~reset & mem_write;
  assign instr_done = ~reset & done;
  assign illegal    = ~reset & illegal_op;
  assign state      = state_reg;

  always_comb begin
    case (op)
      7'b0000011, 7'b0010011: ImmSrc = 3'b000;
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111:             ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    if (alu_op == 2'b01) begin
      ALUControl = 3'b001;
    end else if (alu_op == 2'b10) begin
      case (funct3)
        3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
        3'b001:  ALUControl = 3'b110;
        3'b010:  ALUControl = 3'b101;
        3'b100:  ALUControl = 3'b100;
        3'b101:  ALUControl = 3'b111;
        3'b110:  ALUControl = 3'b011;
        3'b111:  ALUControl = 3'b010;
        default: ALUControl = 3'b000;
      endcase
    end
  end

endmodule
